sst_dump: RTL and testbench
===========================

SST_DUMP -- requirements
Module: sst_dump

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1: one-cycle request to begin a dump.
REQ-004 SHALL have port abort, input, 1: cancels a dump in progress.
REQ-005 SHALL have port sst_addr, output, 8: save-state register address driven to the mapper.
REQ-006 SHALL have port sst_act, output, 1: high while sst_addr is valid.
REQ-007 SHALL have port sst_di, input, 8: mapper register read data; combinational from sst_addr.
REQ-008 SHALL have port out_data, output, 8: dumped byte.
REQ-009 SHALL have port out_valid, output, 1: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1: sink accepts a byte; a transfer occurs when out_valid and out_ready are both high on a clock edge.
REQ-011 SHALL have port busy, output, 1: high from leaving IDLE until returning to it.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on normal completion.
REQ-013 SHALL have port map_idx, output, 8: byte captured from address 127 in the last completed dump.

Function
REQ-014 SHALL implement the states IDLE, SETUP, SAMPLE, OUT, SUM and FIN.
REQ-015 In IDLE, start SHALL clear the address counter to 0 and the checksum to 0, then enter SETUP.
REQ-016 In SETUP, sst_addr SHALL equal the counter and sst_act SHALL be 1 for one cycle; next state is SAMPLE.
REQ-017 In SAMPLE, sst_addr SHALL be held and sst_act SHALL stay 1; sst_di SHALL be registered into out_data; next state is OUT. This gives 2 cycles from address to capture.
REQ-018 In OUT, out_valid SHALL be 1, sst_act SHALL be 0, and out_data SHALL stay stable until a transfer occurs.
REQ-019 On a transfer in OUT at counter 0..126, the counter SHALL increment and the FSM SHALL enter SETUP.
REQ-020 On a transfer in OUT at counter 127, the FSM SHALL enter SUM if the checksum is enabled, otherwise FIN.
REQ-021 When the counter is 127 in SAMPLE, sst_di SHALL also be latched into map_idx.
REQ-022 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-023 The counter SHALL be 7 bits internally; sst_addr[7] SHALL be 0; the counter SHALL never wrap past 127.
REQ-024 start SHALL be ignored whenever busy is 1.
REQ-025 abort SHALL have priority over start, out_ready and every state transition: the next state is IDLE, out_valid and sst_act fall on the next edge, done is not pulsed, and map_idx is unchanged.
REQ-026 If out_ready is held low, the FSM SHALL stay in OUT indefinitely with no timeout.
REQ-027 The minimum dump time with out_ready tied high SHALL be 128 x 3 cycles plus 1 FIN cycle, plus 1 SUM cycle when the checksum is enabled.

Reset
REQ-028 While rst_n is 0, the FSM SHALL be IDLE and the counter 0.
REQ-029 While rst_n is 0, sst_addr, sst_act, out_data, out_valid, busy, done, map_idx and the checksum SHALL all be 0.
REQ-030 A reset asserted mid-dump SHALL discard the dump immediately, without waiting for a clock edge.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the next edge.

Configuration
REQ-032 Macro SST_DUMP_SUM_EN SHALL control the checksum feature.
REQ-033 With SST_DUMP_SUM_EN defined: an 8-bit checksum SHALL accumulate sum mod 256 of each byte at its transfer; SUM presents the two's complement of that sum with out_valid=1 and waits for a transfer before FIN; total output is 129 bytes.
REQ-034 Without SST_DUMP_SUM_EN: no checksum logic SHALL exist, SUM is unreachable, and total output is 128 bytes.

Verification
REQ-035 Model returns sst_di=addr^8'h5A, with 127 returning 8'h69; start with out_ready=1 -> bytes 5A,5B,...; done after 385 cycles (386 with SUM); map_idx=8'h69.
REQ-036 out_ready toggled randomly -> out_data never changes while out_valid=1 and out_ready=0; no byte lost or duplicated.
REQ-037 abort asserted during OUT at counter 40 -> out_valid=0 on the next edge, busy=0, no done pulse, map_idx keeps its prior value.
REQ-038 rst_n pulled low during SAMPLE at counter 10 -> all outputs 0 with no clock edge; a new start afterwards begins again at address 0.
REQ-039 start pulsed during busy -> no effect; exactly 128 (or 129) bytes are emitted.
REQ-040 SST_DUMP_SUM_EN defined, all sst_di=8'h01 -> final byte 8'h80 (128 mod 256 = 8'h80, negated = 8'h80); all sst_di=8'h00 -> final byte 8'h00.

Source files
------------

// File: rtl/sst_dump.sv
// -----------------------------------------------------------------------------
// sst_dump : save-state register dump sequencer
//
// Walks save-state addresses 0..127 through the mapper. For each address it
// waits two cycles for the combinational read data, then presents the byte on
// a valid/ready output port. The byte read at address 127 is also kept as
// map_idx.
//
// Optional feature (macro SST_DUMP_SUM_EN): a 129th byte is appended. It is
// the two's complement of the 8-bit sum of the 128 transferred bytes.
//
// Ports
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  one-cycle dump request (ignored while busy)
//   abort      in   1  cancel dump, highest priority
//   sst_addr   out  8  save-state register address (bit 7 always 0)
//   sst_act    out  1  sst_addr valid
//   sst_di     in   8  mapper read data, combinational from sst_addr
//   out_data   out  8  dumped byte
//   out_valid  out  1  out_data valid
//   out_ready  in   1  sink accepts byte
//   busy       out  1  dump in progress
//   done       out  1  one-cycle pulse on normal completion
//   map_idx    out  8  byte read at address 127 in the last completed dump
// -----------------------------------------------------------------------------
module sst_dump (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [7:0] sst_addr,
  output logic       sst_act,
  input  logic [7:0] sst_di,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] map_idx
);

  // state  | meaning
  // IDLE   | waiting for start
  // SETUP  | address driven, mapper data settling
  // SAMPLE | address held, read data captured
  // OUT    | byte presented, waiting for transfer
  // SUM    | checksum byte presented (SST_DUMP_SUM_EN only)
  // FIN    | done pulse
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] SAMPLE = 3'd2;
  localparam logic [2:0] OUT    = 3'd3;
  localparam logic [2:0] SUM    = 3'd4;
  localparam logic [2:0] FIN    = 3'd5;

  logic [2:0] r_state;
  logic [6:0] r_cnt;
  logic [7:0] r_data;
  logic [7:0] r_map;
  logic       w_last;

`ifdef SST_DUMP_SUM_EN
  logic [7:0] r_sum;
`endif

  assign w_last = (r_cnt == 7'd127);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 7'd0;
      r_data  <= 8'd0;
      r_map   <= 8'd0;
`ifdef SST_DUMP_SUM_EN
      r_sum   <= 8'd0;
`endif
    end else if (abort) begin
      // abort wins over everything; counter/data are reinitialised on next start
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= 7'd0;
`ifdef SST_DUMP_SUM_EN
            r_sum   <= 8'd0;
`endif
            r_state <= SETUP;
          end
        end
        SETUP: r_state <= SAMPLE;
        SAMPLE: begin
          r_data <= sst_di;
          if (w_last) r_map <= sst_di;
          r_state <= OUT;
        end
        OUT: begin
          if (out_ready) begin
`ifdef SST_DUMP_SUM_EN
            r_sum <= r_sum + r_data;
`endif
            if (!w_last) begin
              r_cnt   <= r_cnt + 7'd1;
              r_state <= SETUP;
            end else begin
`ifdef SST_DUMP_SUM_EN
              // the final byte is included here since r_sum updates in parallel
              r_data  <= 8'd0 - (r_sum + r_data);
              r_state <= SUM;
`else
              r_state <= FIN;
`endif
            end
          end
        end
`ifdef SST_DUMP_SUM_EN
        SUM: begin
          if (out_ready) r_state <= FIN;
        end
`endif
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sst_addr  = {1'b0, r_cnt};
  assign sst_act   = (r_state == SETUP) || (r_state == SAMPLE);
  assign out_valid = (r_state == OUT) || (r_state == SUM);
  assign out_data  = r_data;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign map_idx   = r_map;

endmodule

// File: tb/tb_sst_dump.sv
module tb_sst_dump;

`ifdef SST_DUMP_SUM_EN
  localparam int NB  = 129;
  localparam int LAT = 386;
`else
  localparam int NB  = 128;
  localparam int LAT = 385;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] sst_addr;
  logic       sst_act;
  logic [7:0] sst_di;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [7:0] map_idx;

  logic [7:0] mem [128];
  logic [7:0] got [$];
  int         vectors = 0;
  int         errors  = 0;
  int         done_cnt = 0;

  always #5 clk = ~clk;

  // mapper model: register file indexed by the low seven address bits
  always_comb sst_di = mem[sst_addr[6:0]];

  sst_dump dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sst_addr(sst_addr), .sst_act(sst_act), .sst_di(sst_di),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .map_idx(map_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock; logs handshakes and checks hold-while-stalled
  task automatic tick();
    logic       pv, pr, pa;
    logic [7:0] pd;
    pv = out_valid; pr = out_ready; pd = out_data; pa = abort;
    @(posedge clk);
    #1;
    if (pv && pr && !pa) got.push_back(pd);
    if (pv && !pr && !pa && out_valid) chk("stall_hold", out_data, pd);
    if (sst_act) chk("addr_msb", sst_addr[7], 1'b0);
    if (done) done_cnt++;
  endtask

  task automatic run_dump(input bit rnd_ready, input bit poke);
    int         n, bc, done_at;
    logic [7:0] s;
    got.delete();
    done_cnt = 0;
    done_at  = 0;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_act", sst_act, 1);
    chk("start_addr", sst_addr, 0);
    bc = 1;
    n  = 0;
    while (busy && n < 4000) begin
      if (done && done_at == 0) done_at = bc;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke) start = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (busy) bc++;
    end
    start = 1'b0;
    chk("dump_finished", (n < 4000) ? 1 : 0, 1);
    chk("byte_count", got.size(), NB);
    s = 8'd0;
    for (int i = 0; i < 128; i++) begin
      s = s + mem[i];
      if (i < got.size()) chk($sformatf("byte[%0d]", i), got[i], mem[i]);
    end
`ifdef SST_DUMP_SUM_EN
    if (got.size() > 128) chk("checksum", got[128], 8'(9'd256 - s));
`endif
    chk("done_pulses", done_cnt, 1);
    chk("map_idx", map_idx, mem[127]);
    if (!rnd_ready) begin
      chk("busy_cycles", bc, LAT);
      chk("done_at", done_at, LAT);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_addr"}, sst_addr, 0);
    chk({pfx, "_act"}, sst_act, 0);
    chk({pfx, "_data"}, out_data, 0);
    chk({pfx, "_valid"}, out_valid, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_map"}, map_idx, 0);
  endtask

  initial begin
    logic [7:0] prev_map;
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[127] = 8'h69;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_n = 1'b1;

    // reference pattern, sink always ready, first start right after reset
    run_dump(1'b0, 1'b0);
    chk("map_idx_69", map_idx, 8'h69);

    // random contents, random backpressure, start poked while busy
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    run_dump(1'b1, 1'b1);
    prev_map = map_idx;

    // abort in OUT at counter 40 (with out_ready high to test priority)
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[127] = ~prev_map;
    got.delete();
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(out_valid && sst_addr == 8'd40) && n < 500) begin tick(); n++; end
    chk("abort_reached", (n < 500) ? 1 : 0, 1);
    done_cnt = 0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_act", sst_act, 0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", busy, 0);
    chk("abort_map", map_idx, prev_map);

    // asynchronous reset in SAMPLE at counter 10
    for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[127] = 8'h69;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(sst_act && sst_addr == 8'd10) && n < 500) begin tick(); n++; end
    chk("rst_reached", (n < 500) ? 1 : 0, 1);
    tick();
    chk("rst_in_sample", sst_act, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_dump(1'b0, 1'b0);

    // constant patterns (checksum 0x80 and 0x00 when enabled)
    for (int i = 0; i < 128; i++) mem[i] = 8'h01;
    run_dump(1'b0, 1'b1);
`ifdef SST_DUMP_SUM_EN
    if (got.size() == 129) chk("sum_01", got[128], 8'h80);
`endif
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    run_dump(1'b1, 1'b0);
`ifdef SST_DUMP_SUM_EN
    if (got.size() == 129) chk("sum_00", got[128], 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
